// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data; data has priority until a fetch has waited STARVE_LIMIT data grants.
// Latency 2 cycles grant->ack, one transaction in flight; backpressure: requesters hold req and see *_stall until ack.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              if_stall,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        I_WAIT,
        D_WAIT
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       fetch_ok;
    logic       grant_i;
    logic       grant_d;

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        if_ack    = 1'b0;
        if_rdata  = 32'h0;
        d_ack     = 1'b0;
        d_rdata   = 32'h0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        mem_be    = 4'h0;
        fetch_ok  = if_req && !if_flush;

        case (state_q)
            IDLE: begin
                if (!rst) begin
                    if (d_req && !(fetch_ok && starve_q == LIMIT)) begin
                        grant_d = 1'b1;
                    end else if (fetch_ok) begin
                        grant_i = 1'b1;
                    end
                end
            end
            I_WAIT: begin
                state_d = IDLE;
                // A flush landing on the response cycle drops the word silently.
                if (!rst && !if_flush) begin
                    if_ack   = 1'b1;
                    if_rdata = mem_rdata;
                end
            end
            D_WAIT: begin
                state_d = IDLE;
                if (!rst) begin
                    d_ack   = 1'b1;
                    d_rdata = mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_i) begin
            mem_req  = 1'b1;
            mem_addr = if_addr;
            mem_be   = 4'hF;
            state_d  = I_WAIT;
            starve_d = 4'd0;
        end

        if (grant_d) begin
            mem_req   = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_we ? d_be : 4'hF;
            state_d   = D_WAIT;
            // Count only grants that actually made a live fetch wait.
            if (fetch_ok) begin
                starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 4'd1;
            end else if (!if_req) begin
                starve_d = 4'd0;
            end
        end

        if_stall = if_req && !if_ack;
        d_stall  = d_req && !d_ack;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected ack data queued at grant, compared on ack.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        if_stall;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .if_stall(if_stall), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic        chk;
        logic [31:0] data;
    } d_exp_t;

    logic [31:0] if_q[$];
    d_exp_t      d_q[$];
    logic [31:0] ram[0:63];
    logic        mon_en = 1'b0;

    // Memory: read data valid the cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
                mem_rdata <= $urandom;
            end else begin
                mem_rdata <= ram[mem_addr[7:2]];
            end
        end else begin
            mem_rdata <= $urandom;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (if_ack) begin
                if (if_q.size() == 0) check_val("if_ack_unexpected", 32'(if_ack), 0);
                else check_val("if_rdata", if_rdata, if_q.pop_front());
            end else begin
                check_val("if_rdata_idle", if_rdata, 0);
            end
            if (d_ack) begin
                if (d_q.size() == 0) check_val("d_ack_unexpected", 32'(d_ack), 0);
                else begin
                    d_exp_t e;
                    e = d_q.pop_front();
                    if (e.chk) check_val("d_rdata", d_rdata, e.data);
                end
            end else begin
                check_val("d_rdata_idle", d_rdata, 0);
            end
            if (!mem_req) begin
                check_val("mem_idle_ctl", {27'b0, mem_we, mem_be}, 0);
                check_val("mem_idle_addr", mem_addr, 0);
                check_val("mem_idle_wdata", mem_wdata, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
        for (int i = 0; i < 64; i++) ram[i] = 32'h1000_0000 + i;
        ram[1] = 32'hAAAA_AAAA;
        ram[2] = 32'h00A4_8493;
        ram[7] = 32'h1234_5678;

        repeat (2) @(posedge clk);
        mon_en = 1'b1;
        mid();
        check_val("rst_mem_req", 32'(mem_req), 0);
        check_val("rst_acks", {30'b0, if_ack, d_ack}, 0);
        check_val("rst_stalls", {30'b0, if_stall, d_stall}, 0);

        // Fetch alone
        step(); rst = 1'b0; if_req = 1'b1; if_addr = 32'h8;
        mid();
        check_val("f_mem_req", 32'(mem_req), 1);
        check_val("f_mem_addr", mem_addr, 32'h8);
        check_val("f_mem_ctl", {27'b0, mem_we, mem_be}, 32'hF);
        check_val("f_if_stall", 32'(if_stall), 1);
        if_q.push_back(32'h00A4_8493);
        step(); mid();
        check_val("f_if_ack", 32'(if_ack), 1);
        check_val("f_if_stall_ack", 32'(if_stall), 0);
        check_val("f_wait_mem_req", 32'(mem_req), 0);

        // Simultaneous: data first, then fetch
        step(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1C; d_be = 4'h0; d_wdata = 32'h5555_5555;
        mid();
        check_val("s_mem_addr_d", mem_addr, 32'h1C);
        check_val("s_mem_ctl_d", {27'b0, mem_we, mem_be}, 32'hF);
        check_val("s_mem_wdata_d", mem_wdata, 32'h5555_5555);
        check_val("s_stalls", {30'b0, if_stall, d_stall}, 32'h3);
        d_q.push_back('{chk: 1'b1, data: 32'h1234_5678});
        step(); mid();
        check_val("s_d_ack", 32'(d_ack), 1);
        step(); d_req = 1'b0;
        mid();
        check_val("s_fetch_req", 32'(mem_req), 1);
        check_val("s_fetch_addr", mem_addr, 32'h8);
        if_q.push_back(32'h00A4_8493);
        step(); mid();
        check_val("s_if_ack", 32'(if_ack), 1);

        // Starvation: two rounds of 4 data grants then a fetch grant
        step(); d_req = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < 5; s++) begin
                mid();
                check_val("starve_mem_req", 32'(mem_req), 1);
                if (s < 4) begin
                    check_val("starve_data_addr", mem_addr, 32'h1C);
                    d_q.push_back('{chk: 1'b1, data: 32'h1234_5678});
                end else begin
                    check_val("starve_fetch_addr", mem_addr, 32'h8);
                    check_val("starve_d_stall", 32'(d_stall), 1);
                    if_q.push_back(32'h00A4_8493);
                end
                step(); mid(); step();
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        mid();
        check_val("idle_after_starve", 32'(mem_req), 0);

        // Flush in I_WAIT and in IDLE
        step(); if_req = 1'b1; if_addr = 32'h8;
        mid();
        check_val("fl_grant", 32'(mem_req), 1);
        step(); if_flush = 1'b1;
        mid();
        check_val("fl_no_ack", 32'(if_ack), 0);
        step(); mid();
        check_val("fl_idle_no_req", 32'(mem_req), 0);
        check_val("fl_idle_stall", 32'(if_stall), 1);
        step(); d_req = 1'b1; d_addr = 32'h1C;
        mid();
        check_val("fl_data_granted", mem_addr, 32'h1C);
        d_q.push_back('{chk: 1'b1, data: 32'h1234_5678});
        step(); if_flush = 1'b0;
        mid();
        step(); d_req = 1'b0;
        mid();
        check_val("fl_refetch_addr", mem_addr, 32'h8);
        if_q.push_back(32'h00A4_8493);
        step(); mid();

        // Store then read back
        step(); if_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h4;
        d_wdata = 32'hFFFF_FFFE; d_be = 4'b0011;
        mid();
        check_val("st_mem_ctl", {27'b0, mem_we, mem_be}, 32'h13);
        check_val("st_mem_addr", mem_addr, 32'h4);
        check_val("st_mem_wdata", mem_wdata, 32'hFFFF_FFFE);
        d_q.push_back('{chk: 1'b0, data: 32'h0});
        step(); mid();
        check_val("st_d_ack", 32'(d_ack), 1);
        step(); d_we = 1'b0; d_be = 4'h0;
        mid();
        check_val("ld_back_ctl", {27'b0, mem_we, mem_be}, 32'hF);
        d_q.push_back('{chk: 1'b1, data: 32'hAAAA_FFFE});
        step(); mid();
        step(); d_req = 1'b0;

        // Reset in D_WAIT
        step(); d_req = 1'b1; d_addr = 32'h1C;
        mid();
        check_val("rm_grant", 32'(mem_req), 1);
        step(); rst = 1'b1; d_req = 1'b0;
        mid();
        check_val("rm_no_ack", 32'(d_ack), 0);
        step(); rst = 1'b0;
        mid();
        check_val("rm_outs", {27'b0, mem_req, if_ack, d_ack, if_stall, d_stall}, 0);
        check_val("rm_addr", mem_addr, 0);
        step(); if_req = 1'b1; if_addr = 32'h8;
        mid();
        check_val("rm_idle_grant", mem_addr, 32'h8);
        if_q.push_back(32'h00A4_8493);
        step(); mid();
        step(); if_req = 1'b0;
        mid();

        check_val("if_q_drained", 32'(if_q.size()), 0);
        check_val("d_q_drained", 32'(d_q.size()), 0);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, max consecutive data grants while a fetch waits (range 1..15).
REQ-002 Parameter: ADDR_W, 32, byte-address width.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: rst  in  1  synchronous active-high reset.
REQ-006 Port: if_req  in  1  fetch request; held with stable if_addr until if_ack.
REQ-007 Port: if_addr  in  ADDR_W  fetch byte address (word aligned).
REQ-008 Port: if_flush  in  1  discard any outstanding or pending fetch this cycle.
REQ-009 Port: if_ack  out  1  one-cycle pulse; if_rdata valid.
REQ-010 Port: if_rdata  out  32  fetched instruction word.
REQ-011 Port: d_req  in  1  data request; held with stable d_we, d_addr, d_wdata, d_be until d_ack.
REQ-012 Port: d_we  in  1  1 = store, 0 = load.
REQ-013 Port: d_addr  in  ADDR_W  data byte address.
REQ-014 Port: d_wdata  in  32  store data.
REQ-015 Port: d_be  in  4  store byte enables.
REQ-016 Port: d_ack  out  1  one-cycle pulse; load data valid or store committed.
REQ-017 Port: d_rdata  out  32  load data.
REQ-018 Port: if_stall / d_stall  out  1 each  req high and no ack this cycle.
REQ-019 Port: mem_req, mem_we  out  1 each  single shared memory port strobe and write enable.
REQ-020 Port: mem_addr  out  ADDR_W; mem_wdata  out  32; mem_be  out  4  memory command.
REQ-021 Port: mem_rdata  in  32  memory read data, valid the cycle after mem_req.

Function
REQ-022 FSM states: IDLE, I_WAIT, D_WAIT; one transaction in flight; issue only from IDLE.
REQ-023 In IDLE, grant is combinational that cycle: mem_req=1 with the winner's command; state moves to I_WAIT or D_WAIT at the next edge.
REQ-024 Priority: data wins when both request, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
REQ-025 Fetch grant: mem_we=0, mem_be=4'hF, mem_addr=if_addr, mem_wdata=0.
REQ-026 Data grant: mem_we=d_we, mem_be=d_be (forced 4'hF for loads), mem_addr=d_addr, mem_wdata=d_wdata.
REQ-027 No fetch is granted in a cycle with if_flush=1; data may still be granted.
REQ-028 I_WAIT: if_ack=1, if_rdata=mem_rdata, unless if_flush=1 that cycle (ack suppressed, data dropped); always return to IDLE.
REQ-029 D_WAIT: d_ack=1, d_rdata=mem_rdata (loads; don't-care for stores); return to IDLE.
REQ-030 Latency: 2 cycles from IDLE grant to ack; peak throughput one transaction per 2 cycles.
REQ-031 starve_cnt: +1 on a data grant with if_req=1 and if_flush=0; cleared on fetch grant, or on any data grant with if_req=0; saturates at STARVE_LIMIT.
REQ-032 Outside the IDLE grant cycle: mem_req=0 and all mem_* outputs 0.
REQ-033 if_rdata/d_rdata read 0 whenever the matching ack is 0.
REQ-034 A requester deasserting req before ack is a protocol violation; behaviour unspecified except that no ack goes to the other side.

Reset
REQ-035 On rst=1 at a clock edge: state=IDLE, starve_cnt=0; all outputs 0 next cycle.
REQ-036 Reset during I_WAIT or D_WAIT drops the transaction; no ack is produced; a store already strobed into memory is not undone.

Verification
REQ-037 Fetch only: if_req=1, if_addr=0x8, mem holds 0x00A48493 -> mem_req cycle 0, if_ack with if_rdata=0x00A48493 cycle 1, if_stall=1 cycle 0.
REQ-038 Simultaneous: if_req and d_req (load 0x1C) both in IDLE, starve_cnt=0 -> data granted first, d_ack cycle 1, fetch granted cycle 2, if_ack cycle 3.
REQ-039 Starvation: d_req held continuously with a new request after each ack, if_req=1, STARVE_LIMIT=4 -> 4 data grants, then fetch granted on the 5th grant slot, starve_cnt back to 0.
REQ-040 Flush: fetch granted, if_flush=1 in I_WAIT -> no if_ack; if_flush=1 in IDLE with if_req=1, d_req=0 -> mem_req=0.
REQ-041 Store: d_we=1, d_addr=0x4, d_wdata=0xFFFFFFFE, d_be=4'b0011 -> mem_we=1, mem_be=4'b0011 in grant cycle, d_ack next cycle.
REQ-042 Reset mid-op: rst=1 in D_WAIT -> no d_ack, state IDLE, all outputs 0 the following cycle.
